// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bus of the MEM-stage data RAM
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              ready_o;
  logic              rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              fault_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, fault_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, fault_o
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-lane data RAM with clear-on-reset and pipelined loads
module data_memory_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input logic                clk_i,
  input logic                rst_i,
  data_memory_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              init_we;
  logic              ready;
  logic [DATA_W-1:0] mem [DEPTH];

  // State register: every reset restarts the clear sweep at word 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: sweep one word per cycle, then serve requests every cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_we = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  ready = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.ready_o = ready;

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             req_fault;
  logic [3:0]       byte_en;
  logic [DATA_W-1:0] wdata_rep;

  assign accept = bus.req_i & ready;
  assign idx    = bus.addr_i[2 +: IDX_W];
  assign lane   = bus.addr_i[1:0];

  // Request decode: fault conditions, lane enables and lane-replicated store data
  always_comb begin
    req_fault = (bus.size_i == 2'b11)
              | ((bus.size_i == 2'b01) & bus.addr_i[0])
              | ((bus.size_i == 2'b10) & (bus.addr_i[1:0] != 2'b00))
              | (|bus.addr_i[ADDR_W-1:IDX_W+2]);
    byte_en   = 4'b0000;
    wdata_rep = bus.wdata_i;
    case (bus.size_i)
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.wdata_i[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // RAM writes: clear sweep during INIT, enabled lanes on a clean accepted store
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (init_we) begin
        mem[ptr_q] <= '0;
      end else if (accept && bus.we_i && !req_fault) begin
        for (int l = 0; l < 4; l++) begin
          if (byte_en[l]) mem[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
        end
      end
    end
  end

  logic              s0_load, s0_fault, s0_uns;
  logic [1:0]        s0_size, s0_lane;
  logic [DATA_W-1:0] s0_word;
  logic [DATA_W-1:0] ext_data;

  // Stage 1: capture the addressed word and request shape at the accept edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_load  <= 1'b0;
      s0_fault <= 1'b0;
    end else begin
      s0_load  <= accept & ~bus.we_i;
      s0_fault <= accept & req_fault;
    end
    if (accept) begin
      s0_word <= mem[idx];
      s0_size <= bus.size_i;
      s0_lane <= lane;
      s0_uns  <= bus.unsigned_i;
    end
  end

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Lane select and sign/zero extension; zero unless a clean load is present
  always_comb begin
    sel_b    = s0_word[{s0_lane, 3'b000} +: 8];
    sel_h    = s0_lane[1] ? s0_word[31:16] : s0_word[15:0];
    ext_data = '0;
    case (s0_size)
      2'b00:   ext_data = s0_uns ? {{(DATA_W-8){1'b0}}, sel_b}
                                 : {{(DATA_W-8){sel_b[7]}}, sel_b};
      2'b01:   ext_data = s0_uns ? {{(DATA_W-16){1'b0}}, sel_h}
                                 : {{(DATA_W-16){sel_h[15]}}, sel_h};
      default: ext_data = s0_word;
    endcase
    if (!s0_load || s0_fault) ext_data = '0;
  end

  generate
    if (READ_LAT == 1) begin : g_direct
      assign bus.rvalid_o = s0_load;
      assign bus.fault_o  = s0_fault;
      assign bus.rdata_o  = ext_data;
    end else begin : g_pipe
      logic              dl_v [READ_LAT-1];
      logic              dl_f [READ_LAT-1];
      logic [DATA_W-1:0] dl_d [READ_LAT-1];

      // Delay line padding the response out to the configured latency
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int k = 0; k < READ_LAT - 1; k++) begin
            dl_v[k] <= 1'b0;
            dl_f[k] <= 1'b0;
            dl_d[k] <= '0;
          end
        end else begin
          dl_v[0] <= s0_load;
          dl_f[0] <= s0_fault;
          dl_d[0] <= ext_data;
          for (int k = 1; k < READ_LAT - 1; k++) begin
            dl_v[k] <= dl_v[k-1];
            dl_f[k] <= dl_f[k-1];
            dl_d[k] <= dl_d[k-1];
          end
        end
      end

      assign bus.rvalid_o = dl_v[READ_LAT-2];
      assign bus.fault_o  = dl_f[READ_LAT-2];
      assign bus.rdata_o  = dl_d[READ_LAT-2];
    end
  endgenerate
endmodule
